partoserial_lane: RTL and testbench

- Transmit-side lane serializer; the stage directly upstream of the receive lane's serial-to-parallel converter.
- Converts one 8-bit parallel byte stream into a 1-bit serial stream on clk_8f, MSB first.
- Generates its own byte framing from an internal bit counter and pulls bytes from upstream with a request strobe.
- Sends a COM training preamble after reset, and fills every slot that has no valid data with COM, so the receiver can align and detect activity.

---
 rtl/partoserial_lane_pkg.sv | 20 ++
 rtl/partoserial_lane_if.sv | 28 ++
 rtl/partoserial_lane_bit_counter.sv | 29 ++
 rtl/partoserial_lane.sv | 101 ++++++++++
 tb/tb_partoserial_lane.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/partoserial_lane_pkg.sv
// -----------------------------------------------------------------------------
// partoserial_lane_pkg
// Shared lane PHY definitions: byte width, the COM training/filler character,
// the IDLE filler character and the serializer state encoding. The character
// constants are also used by the receive-side aligner.
// No ports.
// -----------------------------------------------------------------------------
package partoserial_lane_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] COM_CHAR_DEF  = 8'hBC;
    localparam logic [BYTE_W-1:0] IDLE_CHAR_DEF = 8'h7C;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } lane_state_e;

endpackage

// File: rtl/partoserial_lane_if.sv
// -----------------------------------------------------------------------------
// partoserial_lane_if
// Upstream byte handshake between a byte source and the lane serializer.
//   data_in  : parallel byte from upstream
//   valid_in : data_in carries payload
//   byte_req : byte-slot strobe; the byte is consumed on the edge where it is high
// Modports: master = byte source, slave = serializer.
// -----------------------------------------------------------------------------
interface partoserial_lane_if;
    import partoserial_lane_pkg::*;

    logic [BYTE_W-1:0] data_in;
    logic              valid_in;
    logic              byte_req;

    modport master (
        output data_in,
        output valid_in,
        input  byte_req
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output byte_req
    );

endinterface

// File: rtl/partoserial_lane_bit_counter.sv
// -----------------------------------------------------------------------------
// lane_bit_counter
// Free-running 3-bit bit-position counter for an 8x bit clock. Resets to 7 so
// the first edge after reset release is a byte load edge. Shared with the
// receive-side deserializer.
// Ports:
//   clk   in  bit clock
//   rst_n in  asynchronous active-low reset
//   load  out high while the counter is at 7 (next edge starts a new byte)
// -----------------------------------------------------------------------------
module lane_bit_counter (
    input  logic clk,
    input  logic rst_n,
    output logic load
);

    logic [2:0] bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 3'd7;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign load = (bit_cnt == 3'd7);

endmodule

// File: rtl/partoserial_lane.sv
// -----------------------------------------------------------------------------
// partoserial_lane
// Transmit-side lane serializer. Converts an 8-bit byte stream into a 1-bit
// MSB-first stream on clk_8f. After reset it sends SYNC_COUNT COM characters
// as a training preamble, then pulls one byte per slot from upstream and fills
// slots without valid data with a filler character.
//
// Optional feature macro: IDLE_CHAR_EN
//   defined   : empty ACTIVE slots carry IDLE_CHAR
//   undefined : empty slots carry COM_CHAR (IDLE_CHAR unused)
//
// State table:
//   state  | meaning
//   SYNC   | sending the COM preamble, upstream ignored, byte_req low
//   ACTIVE | carrying upstream bytes / filler, byte_req every 8 cycles
//
// Ports:
//   clk_8f   in   bit clock, 8x byte rate
//   reset_L  in   asynchronous active-low reset
//   lane     if   slave side of the upstream handshake (data_in, valid_in, byte_req)
//   out      out  registered serial bit stream
//   active   out  registered; preamble done, lane carrying upstream traffic
// -----------------------------------------------------------------------------
module partoserial_lane
    import partoserial_lane_pkg::*;
#(
    parameter int                SYNC_COUNT = 4,
    parameter logic [BYTE_W-1:0] COM_CHAR   = COM_CHAR_DEF,
    parameter logic [BYTE_W-1:0] IDLE_CHAR  = IDLE_CHAR_DEF
) (
    input  logic                clk_8f,
    input  logic                reset_L,
    partoserial_lane_if.slave   lane,
    output logic                out,
    output logic                active
);

`ifdef IDLE_CHAR_EN
    localparam bit USE_IDLE = 1'b1;
`else
    localparam bit USE_IDLE = 1'b0;
`endif

    localparam logic [BYTE_W-1:0] FILL_CHAR = USE_IDLE ? IDLE_CHAR : COM_CHAR;
    localparam logic [3:0]        SYNC_LAST = 4'(SYNC_COUNT - 1);

    lane_state_e       state, state_nxt;
    logic [3:0]        sync_cnt, sync_nxt;
    logic [BYTE_W-1:0] shreg, shreg_nxt;
    logic              load;

    lane_bit_counter u_bit_counter (
        .clk   (clk_8f),
        .rst_n (reset_L),
        .load  (load)
    );

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            state    <= SYNC;
            sync_cnt <= 4'd0;
            shreg    <= '0;
            active   <= 1'b0;
        end else begin
            state    <= state_nxt;
            sync_cnt <= sync_nxt;
            shreg    <= shreg_nxt;
            active   <= (state_nxt == ACTIVE);
        end
    end

    always_comb begin
        state_nxt = state;
        sync_nxt  = sync_cnt;
        shreg_nxt = {shreg[BYTE_W-2:0], 1'b0};
        if (load) begin
            unique case (state)
                SYNC: begin
                    shreg_nxt = COM_CHAR;
                    // Last preamble byte: switch over, counter parks at its final value.
                    if (sync_cnt == SYNC_LAST) begin
                        state_nxt = ACTIVE;
                    end else begin
                        sync_nxt = sync_cnt + 4'd1;
                    end
                end
                ACTIVE: begin
                    shreg_nxt = lane.valid_in ? lane.data_in : FILL_CHAR;
                end
                default: begin
                    state_nxt = SYNC;
                end
            endcase
        end
    end

    // Decoded only from flops so upstream sees a clean Moore strobe.
    assign lane.byte_req = (state == ACTIVE) && load;
    assign out           = shreg[BYTE_W-1];

endmodule

// File: tb/tb_partoserial_lane.sv
// -----------------------------------------------------------------------------
// tb_partoserial_lane
// Scoreboard bench for partoserial_lane. The driver decides the content of each
// byte slot and pushes the expected transmitted byte; the monitor reassembles
// the serial stream per slot and compares, and also checks byte_req / active
// against their slot timing. Set IDLE_CHAR_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_partoserial_lane;

    localparam int         SC  = 4;
    localparam logic [7:0] COM = 8'hBC;
`ifdef IDLE_CHAR_EN
    localparam logic [7:0] FILL = 8'h7C;
`else
    localparam logic [7:0] FILL = 8'hBC;
`endif

    typedef struct {
        logic       v;
        logic [7:0] d;
    } slot_t;

    logic clk_8f  = 1'b0;
    logic reset_L = 1'b0;
    logic out;
    logic active;

    partoserial_lane_if lane_bus ();

    partoserial_lane dut (
        .clk_8f  (clk_8f),
        .reset_L (reset_L),
        .lane    (lane_bus),
        .out     (out),
        .active  (active)
    );

    always #5 clk_8f = ~clk_8f;

    // Edges seen since the last reset release.
    int edges;
    always @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) edges <= 0;
        else          edges <= edges + 1;
    end

    logic [7:0] exp_q[$];
    slot_t      plan[$];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t, edges=%0d)", name, act, exp, $time, edges);
        end
    endtask

    // Monitor: after k edges since release, bit (k-1)%8 of slot (k-1)/8 is on out.
    int         mt, mk;
    logic [7:0] cur, got;
    always @(negedge clk_8f) begin
        if (reset_L) begin
            mt = edges;
            check("byte_req", 8'(lane_bus.byte_req), 8'((mt % 8 == 0) && (mt >= 8 * SC)));
            check("active",   8'(active),            8'(mt >= 8 * (SC - 1) + 1));
            if (mt == 0) begin
                check("out_idle", 8'(out), 8'd0);
            end else begin
                mk = (mt - 1) % 8;
                if (mk == 0) begin
                    got = 8'd0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL scoreboard_empty: got no expected byte want one (edges=%0d)", mt);
                        cur = 8'hxx;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                got[7-mk] = out;
                if (mk == 7) check("serial_byte", got, cur);
            end
        end
    end

    // Driver step for the cycle before the next edge.
    task automatic step();
        int    t;
        slot_t sl;
        t = edges;
        if (t % 8 == 0) begin
            if (t / 8 < SC) begin
                lane_bus.valid_in = 1'($urandom);
                lane_bus.data_in  = 8'($urandom);
                exp_q.push_back(COM);
            end else begin
                if (plan.size() > 0) begin
                    sl = plan.pop_front();
                end else begin
                    sl.v = 1'($urandom);
                    sl.d = 8'($urandom);
                end
                lane_bus.valid_in = sl.v;
                lane_bus.data_in  = sl.d;
                exp_q.push_back(sl.v ? sl.d : FILL);
            end
        end else begin
            // Off-slot noise must never reach the line.
            lane_bus.valid_in = 1'($urandom);
            lane_bus.data_in  = 8'($urandom);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            @(negedge clk_8f);
        end
    endtask

    task automatic add_slot(input logic v, input logic [7:0] d);
        slot_t s;
        s.v = v;
        s.d = d;
        plan.push_back(s);
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_out"},      8'(out),               8'd0);
        check({tag, "_active"},   8'(active),            8'd0);
        check({tag, "_byte_req"}, 8'(lane_bus.byte_req), 8'd0);
    endtask

    initial begin
        lane_bus.data_in  = 8'h00;
        lane_bus.valid_in = 1'b0;
        #1;
        check_in_reset("por");
        repeat (3) @(negedge clk_8f);

        // Payload slots 4..23: directed cases, random fill, then 0xFF in slot 23.
        add_slot(1'b1, 8'hA5);
        add_slot(1'b0, 8'h5A);
        add_slot(1'b0, 8'hC3);
        add_slot(1'b0, 8'h11);
        add_slot(1'b1, 8'h00);
        add_slot(1'b1, 8'hFF);
        add_slot(1'b1, 8'hBC);
        for (int i = 0; i < 12; i++) add_slot(1'($urandom), 8'($urandom));
        add_slot(1'b1, 8'hFF);

        reset_L = 1'b1;
        run(8 * 23 + 4);

        // Slot 23 (0xFF) is half sent: out is 1 before the async reset hits.
        #2;
        check("pre_reset_out", 8'(out), 8'd1);
        reset_L = 1'b0;
        #1;
        check_in_reset("mid");
        exp_q.delete();
        plan.delete();
        repeat (2) begin
            @(negedge clk_8f);
            check_in_reset("hold");
        end

        @(negedge clk_8f);
        reset_L = 1'b1;
        run(8 * (SC + 20));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
